// File: rtl/rr_arbiter16_if.sv
// rr_arbiter16_if: request/grant bundle between the 16 requesters and the
// round-robin arbiter that owns the shared decoded resource.
interface rr_arbiter16_if;
  logic [15:0] req;
  logic        rel;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
  logic        tmo;

  // Requester side: raises requests and releases ownership.
  modport master (
    output req,
    output rel,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  tmo
  );

  // Arbiter side: samples requests and drives the one-hot select lines.
  modport slave (
    input  req,
    input  rel,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output tmo
  );
endinterface

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with registered one-hot grant.
// Cycle is IDLE (arbitrate) -> GRANT (hold until release/withdrawal) -> GAP
// (one dead cycle) -> IDLE, so ownership never passes directly between two
// requesters. Optional hold-time limit is built when RR_ARB_TIMEOUT_EN is
// defined; otherwise tmo is tied low and MAX_HOLD is not used by the logic.
module rr_arbiter16 #(
  parameter int MAX_HOLD = 64
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter16_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Reject an out-of-range hold limit at elaboration time.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter16: MAX_HOLD must be in 1..255");
  end

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  gnt_idx_q, gnt_idx_d;
  logic        gnt_vld_q, gnt_vld_d;
  logic [15:0] gnt_q, gnt_d;
  logic        tmo_q, tmo_d;

  logic [3:0]  win_idx;
  logic        win_found;
  logic        timeout;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;

  // Last GRANT cycle of a grant that has been held MAX_HOLD cycles.
  assign timeout = (state_q == ST_GRANT) && (hold_q == HOLD_LAST);

  // Hold counter: zero on entry to GRANT, counts every GRANT cycle.
  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_IDLE) begin
      hold_d = '0;
    end else if (state_q == ST_GRANT) begin
      hold_d = hold_q + 8'd1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search: first set request above ptr, wrapping 15 -> 0.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    logic [3:0] cand;
    win_idx   = ptr_q;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= 16; i++) begin
      cand = ptr_q + 4'(i);
      if (!win_found && bus.req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    tmo_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_idx_d = win_idx;
          ptr_d     = win_idx;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (bus.rel || !bus.req[gnt_idx_q] || timeout) begin
          state_d = ST_GAP;
          // An explicit release wins over a coincident timeout.
          tmo_d   = timeout && !bus.rel;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    gnt_vld_d = (state_d == ST_GRANT);
    gnt_d     = gnt_vld_d ? (16'd1 << gnt_idx_d) : 16'd0;
  end

  // State and output registers; ptr resets to 15 so requester 0 leads.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 4'd15;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      gnt_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_q     <= gnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;
`ifdef RR_ARB_TIMEOUT_EN
  assign bus.tmo     = tmo_q;
`else
  assign bus.tmo     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: directed self-checking bench for rr_arbiter16.
// Timeout scenario is exercised when RR_ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rr_arbiter16_if arb_bus ();

  rr_arbiter16 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [3:0] idx);
    check({tag, " vld"}, 32'(arb_bus.gnt_vld), 32'd1);
    check({tag, " idx"}, 32'(arb_bus.gnt_idx), 32'(idx));
    check({tag, " gnt"}, 32'(arb_bus.gnt), 32'(16'd1 << idx));
  endtask

  task automatic check_idle(input string tag);
    check({tag, " vld"}, 32'(arb_bus.gnt_vld), 32'd0);
    check({tag, " gnt"}, 32'(arb_bus.gnt), 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    arb_bus.req = '0;
    arb_bus.rel = 1'b0;
    tick();
    tick();

    // Reset state.
    check_idle("reset");
    check("reset idx", 32'(arb_bus.gnt_idx), 32'd0);
    check("reset tmo", 32'(arb_bus.tmo), 32'd0);
    rst = 1'b0;

    // Single requester: grant, release, GAP, IDLE, regrant.
    arb_bus.req = 16'h0001;
    tick();
    check_grant("t1 grant", 4'd0);
    arb_bus.rel = 1'b1;
    tick();
    arb_bus.rel = 1'b0;
    check_idle("t1 gap");
    tick();
    check_idle("t1 idle");
    check("t1 idle idx hold", 32'(arb_bus.gnt_idx), 32'd0);
    tick();
    check_grant("t1 regrant", 4'd0);
    arb_bus.req = 16'h0000;
    tick();
    check_idle("t1 withdraw gap");
    tick();

    // Full rotation from reset pointer: 0,1,...,15,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    arb_bus.req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      tick();
      check_grant($sformatf("rot%0d", k), 4'(k));
      arb_bus.rel = 1'b1;
      tick();
      arb_bus.rel = 1'b0;
      check("rot gap vld", 32'(arb_bus.gnt_vld), 32'd0);
      tick();
      check("rot idle vld", 32'(arb_bus.gnt_vld), 32'd0);
    end

    // Grant 5, then 0x0021 must wrap to requester 0.
    arb_bus.req = 16'h0020;
    tick();
    check_grant("t3 grant5", 4'd5);
    arb_bus.req = 16'h0021;
    arb_bus.rel = 1'b1;
    tick();
    arb_bus.rel = 1'b0;
    check_idle("t3 gap");
    tick();
    tick();
    check_grant("t3 wrap", 4'd0);

    // Grant 3, then requester 3 withdraws without rel.
    arb_bus.req = 16'h0008;
    tick();
    check_idle("t4 gap0");
    tick();
    tick();
    check_grant("t4 grant3", 4'd3);
    tick();
    check_grant("t4 held", 4'd3);
    arb_bus.req = 16'h0000;
    tick();
    check_idle("t4 gap");
    check("t4 gap tmo", 32'(arb_bus.tmo), 32'd0);
    tick();
    check_idle("t4 idle");
    check("t4 idle tmo", 32'(arb_bus.tmo), 32'd0);

`ifdef RR_ARB_TIMEOUT_EN
    // Timeout: grant to 8 lasts exactly 4 cycles, tmo pulses, then reissued.
    arb_bus.req = 16'h0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_grant($sformatf("t5 hold%0d", c), 4'd8);
      check("t5 hold tmo", 32'(arb_bus.tmo), 32'd0);
    end
    tick();
    check_idle("t5 gap");
    check("t5 gap tmo", 32'(arb_bus.tmo), 32'd1);
    tick();
    check_idle("t5 idle");
    check("t5 idle tmo", 32'(arb_bus.tmo), 32'd0);
    tick();
    check_grant("t5 reissue", 4'd8);
`else
    // No timeout built: a held grant never expires and tmo stays low.
    arb_bus.req = 16'h0100;
    tick();
    check_grant("t5 grant8", 4'd8);
    for (int c = 0; c < 70; c++) begin
      tick();
      if (arb_bus.gnt_vld !== 1'b1 || arb_bus.tmo !== 1'b0) begin
        check($sformatf("t5 hold cyc%0d", c),
              {30'd0, arb_bus.gnt_vld, arb_bus.tmo}, 32'b10);
      end
    end
    check_grant("t5 still held", 4'd8);
    check("t5 tmo", 32'(arb_bus.tmo), 32'd0);
`endif
    arb_bus.req = 16'h0000;
    tick();
    tick();

    // Reset during third cycle of a grant to 4.
    arb_bus.req = 16'h0010;
    tick();
    check_grant("t6 cyc1", 4'd4);
    tick();
    tick();
    check_grant("t6 cyc3", 4'd4);
    rst         = 1'b1;
    arb_bus.req = 16'h8001;
    tick();
    check_idle("t6 reset");
    check("t6 reset idx", 32'(arb_bus.gnt_idx), 32'd0);
    check("t6 reset tmo", 32'(arb_bus.tmo), 32'd0);
    rst = 1'b0;
    tick();
    check_grant("t6 after reset", 4'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
